// File: rtl/light_pkg.sv
// Shared types and constants for the intersection light controller
// (phase encodings, one-hot load codes, default phase times).
package light_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } phase_t;

  localparam int unsigned INIT_WIDTH      = 3;
  localparam int unsigned INIT_GREEN_BIT  = 0;
  localparam int unsigned INIT_YELLOW_BIT = 1;
  localparam int unsigned INIT_RED_BIT    = 2;

  localparam logic [INIT_WIDTH-1:0] ONEHOT_GREEN  = INIT_WIDTH'(1) << INIT_GREEN_BIT;
  localparam logic [INIT_WIDTH-1:0] ONEHOT_YELLOW = INIT_WIDTH'(1) << INIT_YELLOW_BIT;
  localparam logic [INIT_WIDTH-1:0] ONEHOT_RED    = INIT_WIDTH'(1) << INIT_RED_BIT;

  localparam int unsigned TIME_GREEN  = 15;
  localparam int unsigned TIME_YELLOW = 3;
  localparam int unsigned TIME_RED    = 18;
  localparam int unsigned CNT_WIDTH   = 5;

  // Counter load request for a phase; unknown encodings fall back to GREEN.
  function automatic logic [INIT_WIDTH-1:0] phase_onehot(input logic [1:0] ph);
    case (ph)
      YELLOW:  return ONEHOT_YELLOW;
      RED:     return ONEHOT_RED;
      default: return ONEHOT_GREEN;
    endcase
  endfunction

  function automatic logic [1:0] phase_next(input logic [1:0] ph);
    case (ph)
      GREEN:   return YELLOW;
      YELLOW:  return RED;
      default: return GREEN;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider producing a one-cycle count tick every
// pTICK_DIV cycles; freezes while hold is high.
module tick_prescaler #(
  parameter int unsigned pTICK_DIV  = 50000000,
  parameter int unsigned pDIV_WIDTH = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic tick
);

  localparam logic [pDIV_WIDTH-1:0] LAST = pDIV_WIDTH'(pTICK_DIV - 1);

  logic [pDIV_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!hold) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = !hold && (count == LAST);

endmodule

// File: rtl/light_sequencer.sv
// Main-road phase controller: paces the countdown counter, steps
// GREEN -> YELLOW -> RED and decodes main and side-road lamps.
module light_sequencer
  import light_pkg::*;
#(
  parameter int unsigned pTIME_YELLOW_LIGHT = TIME_YELLOW,
  parameter int unsigned pCNT_WIDTH         = CNT_WIDTH,
  parameter int unsigned pINIT_WIDTH        = INIT_WIDTH,
  parameter int unsigned pTICK_DIV          = 50000000,
  parameter int unsigned pDIV_WIDTH         = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic                   last,
  input  logic [pCNT_WIDTH-1:0]  cnt_in,
  output logic                   en,
  output logic [pINIT_WIDTH-1:0] init,
  output logic [1:0]             phase,
  output logic                   main_g,
  output logic                   main_y,
  output logic                   main_r,
  output logic                   side_g,
  output logic                   side_y,
  output logic                   side_r
);

  localparam logic [pCNT_WIDTH-1:0] SIDE_YELLOW_CNT = pCNT_WIDTH'(pTIME_YELLOW_LIGHT);

  logic                   tick;
  logic                   init_pending;
  logic                   advance;
  logic [1:0]             phase_q;
  logic [1:0]             phase_d;
  logic [pINIT_WIDTH-1:0] init_q;
  logic [pINIT_WIDTH-1:0] init_d;

  tick_prescaler #(
    .pTICK_DIV  (pTICK_DIV),
    .pDIV_WIDTH (pDIV_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .hold (hold),
    .tick (tick)
  );

  assign init_pending = |init_q;

  // State register; reset issues the GREEN load on the first cycle after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= GREEN;
      init_q  <= pINIT_WIDTH'(ONEHOT_GREEN);
    end else begin
      phase_q <= phase_d;
      init_q  <= init_d;
    end
  end

  // Advance only on a tick at count 0, and never while a load is still in flight.
  always_comb begin
    phase_d = phase_q;
    init_d  = '0;
    advance = tick && last && !init_pending;
    case (phase_q)
      GREEN, YELLOW, RED: begin
        if (advance) begin
          phase_d = phase_next(phase_q);
          init_d  = pINIT_WIDTH'(phase_onehot(phase_next(phase_q)));
        end
      end
      default: begin
        phase_d = GREEN;
        init_d  = pINIT_WIDTH'(ONEHOT_GREEN);
      end
    endcase
  end

  // Tick gating and lamp decode from the registered phase and live count.
  always_comb begin
    en     = tick && !init_pending;
    init   = init_q;
    phase  = phase_q;
    main_g = 1'b0;
    main_y = 1'b0;
    main_r = 1'b0;
    side_g = 1'b0;
    side_y = 1'b0;
    side_r = 1'b0;
    case (phase_q)
      YELLOW: begin
        main_y = 1'b1;
        side_r = 1'b1;
      end
      RED: begin
        main_r = 1'b1;
        if (cnt_in > SIDE_YELLOW_CNT) side_g = 1'b1;
        else                          side_y = 1'b1;
      end
      default: begin
        main_g = 1'b1;
        side_r = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer with a behavioural countdown counter attached,
// a per-cycle reference model and directed timing scenarios.
module tb_light_sequencer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       hold;
  logic       last;
  logic [4:0] cnt_in;
  logic       en;
  logic [2:0] init;
  logic [1:0] phase;
  logic       main_g, main_y, main_r, side_g, side_y, side_r;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  light_sequencer #(
    .pTIME_YELLOW_LIGHT (3),
    .pCNT_WIDTH         (5),
    .pINIT_WIDTH        (3),
    .pTICK_DIV          (4),
    .pDIV_WIDTH         (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .hold   (hold),
    .last   (last),
    .cnt_in (cnt_in),
    .en     (en),
    .init   (init),
    .phase  (phase),
    .main_g (main_g),
    .main_y (main_y),
    .main_r (main_r),
    .side_g (side_g),
    .side_y (side_y),
    .side_r (side_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Countdown counter seen by the sequencer (loads 15/3/18, reset holds 15)
  always @(posedge clk or posedge rst) begin
    if (rst)                     cnt_in <= 5'd15;
    else if (init[0])            cnt_in <= 5'd15;
    else if (init[1])            cnt_in <= 5'd3;
    else if (init[2])            cnt_in <= 5'd18;
    else if (en && cnt_in != 0)  cnt_in <= cnt_in - 5'd1;
  end
  assign last = (cnt_in == 5'd0);

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lamps_now();
    return int'({main_g, main_y, main_r, side_g, side_y, side_r});
  endfunction

  function automatic int load_of(input int p);
    return (p == 0) ? 15 : (p == 1) ? 3 : 18;
  endfunction

  // Reference model: prescaler position, phase, expected count, load-cycle flag
  int m_pre, m_phase, m_cnt;
  bit m_init, m_tick;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pre = 0; m_phase = 0; m_cnt = 15; m_init = 1'b1;
    end else begin
      m_tick = (m_pre == DIV - 1) && !hold;
      if (!hold) m_pre = (m_pre + 1) % DIV;
      if (m_init) begin
        m_init = 1'b0;
        m_cnt  = load_of(m_phase);
      end else if (m_tick) begin
        if (m_cnt == 0) begin
          m_phase = (m_phase + 1) % 3;
          m_init  = 1'b1;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  end

  int exp_main, exp_side;
  logic [2:0] prev_init = 3'b000;

  always @(negedge clk) begin
    if (!rst) begin
      exp_main = (m_phase == 0) ? 4 : (m_phase == 1) ? 2 : 1;
      exp_side = (m_phase != 2) ? 1 : (m_cnt > 3) ? 4 : 2;
      check("phase", int'(phase), m_phase);
      check("init", int'(init), m_init ? (1 << m_phase) : 0);
      check("en", int'(en), int'((m_pre == DIV - 1) && !hold && !m_init));
      check("cnt", int'(cnt_in), m_cnt);
      check("lamps", lamps_now(), exp_main * 8 + exp_side);
      check("green_conflict", int'(main_g & side_g), 0);
      check("init_back_to_back", int'((prev_init != 0) && (init != 0)), 0);
      prev_init = init;
    end else begin
      prev_init = 3'b000;
    end
  end

  task automatic wait_init(input string name, input int budget, output int at, output int sg);
    sg = 0;
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (init != 0) begin
        at = cyc;
        break;
      end
      if (side_g) sg++;
    end
    if (at < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no init pulse within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_cnt(input string name, input int v, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (int'(cnt_in) == v) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: count %0d not reached within %0d cycles", name, v, budget);
    end
  endtask

  int t_g, t_y, t_r, t_g2, t_g3, sg, n_wait;
  bit found;

  initial begin
    rst  = 1'b1;
    hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lamps", lamps_now(), 33);
    check("rst_init", int'(init), 1);
    check("rst_en", int'(en), 0);
    check("rst_phase", int'(phase), 0);

    // 1: release reset -> GREEN load pulse, no tick
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rel_init", int'(init), 1);
    check("rel_en", int'(en), 0);
    check("rel_lamps", lamps_now(), 33);
    check("rel_cnt", int'(cnt_in), 15);
    t_g = cyc;

    // 2-3: full cycle timing, 16/4/19 ticks of 4 clocks
    wait_init("to_yellow", 200, t_y, sg);
    check("y_init", int'(init), 2);
    check("y_en", int'(en), 0);
    check("green_len", t_y - t_g, 64);
    @(negedge clk);
    check("y_load", int'(cnt_in), 3);
    wait_init("to_red", 200, t_r, sg);
    check("r_init", int'(init), 4);
    check("yellow_len", t_r - t_y, 16);
    @(negedge clk);
    check("r_load", int'(cnt_in), 18);
    check("r_side_g", int'(side_g), 1);
    wait_init("to_green", 200, t_g2, sg);
    check("g_init", int'(init), 1);
    check("red_len", t_g2 - t_r, 76);
    check("side_g_cycles", sg + 1, 59);
    check("cycle_len", t_g2 - t_g, 156);

    // 4: hold for 20 cycles at count 9
    wait_cnt("to10", 10, 200);
    wait_cnt("to9", 9, 20);
    @(posedge clk); #1 hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_en", int'(en), 0);
      check("hold_cnt", int'(cnt_in), 9);
    end
    @(posedge clk); #1 hold = 1'b0;
    n_wait = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (en) break;
      n_wait++;
    end
    check("hold_resume", n_wait, 2);

    // 5: hold exactly on the due tick at count 0
    wait_cnt("to1", 1, 200);
    wait_cnt("to0", 0, 20);
    repeat (3) @(posedge clk);
    #1 hold = 1'b1;
    @(posedge clk); #1 hold = 1'b0;
    @(negedge clk);
    check("held_phase", int'(phase), 0);
    check("held_init", int'(init), 0);
    @(negedge clk);
    check("late_phase", int'(phase), 1);
    check("late_init", int'(init), 2);

    // 6: reset pulse during RED at count 7
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (phase == 2'd2 && cnt_in == 5'd7) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL red7: RED at count 7 not reached");
    end
    #2 rst = 1'b1;
    #1;
    check("async_lamps", lamps_now(), 33);
    check("async_phase", int'(phase), 0);
    check("async_init", int'(init), 1);
    check("async_en", int'(en), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rel2_init", int'(init), 1);
    check("rel2_cnt", int'(cnt_in), 15);
    t_g3 = cyc;
    wait_init("to_yellow2", 200, t_y, sg);
    check("y2_init", int'(init), 2);
    check("green2_len", t_y - t_g3, 64);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
